addsub_fu: RTL and testbench
============================

// Module: addsub_fu
// PURPOSE
//  Add/subtract functional unit: responder for the despacho/confirma dispatch handshake issued by the
//  add/sub reservation stations, and producer of their results on the common data bus (CDB).
//  Accepts one operation at a time, executes in LATENCY cycles, and requests the bus from the CDB arbiter.
//  On grant it broadcasts {tag,result} for one cycle and pulses confirma to free the issuing station.
// PARAMETERS
//  LATENCY  2   execute cycles between acceptance and CDB request; legal 1..15
//  DATA_W   16  operand/result width
//  TAG_W    3   station tag width; tag 0 = "no producer", never broadcast
// PORTS
//  CLK        in   1        clock, rising edge
//  CLR        in   1        reset, asynchronous, active-high
//  despacho   in   1        station holds operands valid; stays high until it samples confirma
//  Valor1     in   DATA_W   operand A (Vj)
//  Valor2     in   DATA_W   operand B (Vk)
//  OP         in   3        OP[0]=0 add, OP[0]=1 sub (A-B); OP[2:1] ignored
//  ID_in      in   TAG_W    issuing station tag
//  cdb_grant  in   1        arbiter grant; only honoured while cdb_req=1
//  confirma   out  1        one-cycle pulse, coincident with the broadcast
//  cdb_req    out  1        bus request
//  CDB        out  TAG_W+DATA_W  {tag,result}; all zero when not broadcasting
//  busy       out  1        high in every state except IDLE
//  ovf        out  1        signed overflow qualifier of the broadcast (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs are registered. CLR asserted: state=IDLE, counter=0, all outputs 0, latched operands cleared.
//  - IDLE: accept when despacho=1 and ID_in!=0; latch tag, compute A+B or A-B (mod 2^DATA_W,
//    carry/borrow discarded) into the result register, counter=LATENCY-1, go to EXEC.
//    despacho with ID_in=0 is ignored (no accept, no confirma).
//  - EXEC: counter decrements each edge; at counter=0 go to WAIT_CDB. Input changes here are ignored.
//  - WAIT_CDB: cdb_req=1; edge with cdb_grant=1 -> BCAST; otherwise hold. No timeout.
//  - BCAST (exactly 1 cycle): CDB={tag,result}, confirma=1, cdb_req=0; next edge -> IDLE, CDB=0, confirma=0.
//  - Latency: with grant held high, CDB is valid in the cycle after the (LATENCY+1)th rising edge
//    that follows the accepting edge.
//  - cdb_grant outside WAIT_CDB: ignored; req never asserted speculatively.
//  - The station drops despacho on the edge ending BCAST, so the IDLE cycle after BCAST sees only a new
//    dispatch. A new dispatch is accepted on that cycle's closing edge (one IDLE cycle minimum between ops).
//  - CLR mid-operation (any state): immediate abort; no broadcast or confirma is produced for the lost op.
//  - Only one op in flight; back-pressure is implicit (despacho stays high while busy=1).
// CONFIGURATION
//  - FU_OVF_DETECT_EN defined: ovf is registered with the result (signed overflow of A+B or A-B) and
//    driven high only during BCAST when overflow occurred; 0 otherwise.
//  - FU_OVF_DETECT_EN undefined: ovf is tied to 0; no overflow logic is synthesised.
// TESTING
//  1. LATENCY=2, grant=1, A=0x0005 B=0x0003 OP=000 ID=3 -> CDB=0x3_0008 and confirma=1 for exactly
//     one cycle, 3 edges after the accepting edge; busy low afterwards.
//  2. A=0x0000 B=0x0001 OP=001 ID=2 -> CDB=0x2_FFFF (wrap-around); OP=101 gives the same result.
//  3. grant withheld 5 cycles: cdb_req high, CDB=0 throughout; Valor1/Valor2 changed mid-wait ->
//     broadcast still carries the originally latched result on the first granted cycle.
//  4. Back-to-back: op ID=3 completes, station ID=5 already waiting with despacho=1 -> ID=5 accepted
//     on the IDLE cycle after BCAST; exactly one broadcast per tag, no duplicate for ID=3.
//  5. CLR pulsed during EXEC -> busy/cdb_req/confirma/CDB=0 immediately; no later broadcast.
//     ID_in=0 with despacho=1 -> never accepted, busy stays 0.
//  6. A=0x7FFF B=0x0001 OP=000 ID=1 -> CDB=0x1_8000; ovf=1 during BCAST with FU_OVF_DETECT_EN,
//     ovf=0 without it.

Source files
------------

// File: rtl/addsub_fu.sv
// Add/subtract functional unit answering the despacho/confirma handshake and broadcasting {tag,result} on the CDB.
// Optional build macro FU_OVF_DETECT_EN: registers a signed-overflow flag with the result and drives it on ovf during BCAST.
module addsub_fu #(
    parameter int LATENCY = 2,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic                      despacho,
    input  logic [DATA_W-1:0]         Valor1,
    input  logic [DATA_W-1:0]         Valor2,
    input  logic [2:0]                OP,
    input  logic [TAG_W-1:0]          ID_in,
    input  logic                      cdb_grant,
    output logic                      confirma,
    output logic                      cdb_req,
    output logic [TAG_W+DATA_W-1:0]   CDB,
    output logic                      busy,
    output logic                      ovf
);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT_CDB, BCAST} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                    state, state_nxt;
    logic [3:0]                cnt, cnt_nxt;
    logic                      accept;
    logic signed [DATA_W-1:0]  a_s, b_s, sum_s;
    logic [TAG_W-1:0]          tag_p0;
    logic signed [DATA_W-1:0]  res_p0;
    logic                      op_unused;

    assign op_unused = ^OP[2:1];
    assign a_s       = Valor1;
    assign b_s       = Valor2;
    assign sum_s     = OP[0] ? (a_s - b_s) : (a_s + b_s);
    assign accept    = (state == IDLE) && despacho && (ID_in != '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                    cnt_nxt   = CNT_INIT;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) state_nxt = WAIT_CDB;
                else             cnt_nxt   = cnt - 4'd1;
            end
            WAIT_CDB: begin
                if (cdb_grant) state_nxt = BCAST;
            end
            BCAST:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            tag_p0   <= '0;
            res_p0   <= '0;
            busy     <= 1'b0;
            cdb_req  <= 1'b0;
            confirma <= 1'b0;
            CDB      <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            busy     <= (state_nxt != IDLE);
            cdb_req  <= (state_nxt == WAIT_CDB);
            confirma <= (state_nxt == BCAST);
            CDB      <= (state_nxt == BCAST) ? {tag_p0, res_p0} : '0;
            if (accept) begin
                tag_p0 <= ID_in;
                res_p0 <= sum_s;
            end
        end
    end

`ifdef FU_OVF_DETECT_EN
    logic ovf_p0;

    function automatic logic signed_ovf(input logic sub,
                                        input logic signed [DATA_W-1:0] a,
                                        input logic signed [DATA_W-1:0] b,
                                        input logic signed [DATA_W-1:0] r);
        logic same_in;
        same_in = sub ? (a[DATA_W-1] != b[DATA_W-1]) : (a[DATA_W-1] == b[DATA_W-1]);
        return same_in && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ovf_p0 <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (accept) ovf_p0 <= signed_ovf(OP[0], a_s, b_s, sum_s);
            ovf <= (state_nxt == BCAST) && ovf_p0;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_fu.sv
// Self-checking bench for addsub_fu: timestamp-based reference model, per-cycle compare, directed and random ops.
module tb_addsub_fu;
    localparam int L  = 2;
    localparam int DW = 16;
    localparam int TW = 3;
`ifdef FU_OVF_DETECT_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic clk = 1'b0, clr = 1'b1, despacho = 1'b0, grant = 1'b0;
    logic [DW-1:0] v1 = '0, v2 = '0;
    logic [2:0]    op = '0;
    logic [TW-1:0] id = '0;
    logic          confirma, cdb_req, busy, ovf;
    logic [TW+DW-1:0] cdb;

    int checks = 0, errors = 0;
    int m_bcasts = 0, dut_bcasts = 0;

    always #5 clk = ~clk;

    addsub_fu #(.LATENCY(L), .DATA_W(DW), .TAG_W(TW)) dut (
        .CLK(clk), .CLR(clr), .despacho(despacho), .Valor1(v1), .Valor2(v2), .OP(op),
        .ID_in(id), .cdb_grant(grant), .confirma(confirma), .cdb_req(cdb_req),
        .CDB(cdb), .busy(busy), .ovf(ovf)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an accepted op requests the bus L edges after acceptance and
    // broadcasts on the first later edge that sees grant; the next edge frees the unit.
    bit            m_inf = 0, m_bc = 0, m_ovf = 0;
    int            ecnt = 0, m_acc = 0;
    logic [TW-1:0] m_tag = '0;
    logic [DW-1:0] m_res = '0;

    initial forever begin
        @(posedge clk or posedge clr);
        if (clr) begin
            m_inf = 0;
            m_bc  = 0;
        end else begin
            ecnt++;
            if (m_bc) begin
                m_bc  = 0;
                m_inf = 0;
            end else if (!m_inf) begin
                if (despacho && id != 0) begin
                    int sa, sb, r;
                    sa    = $signed(v1);
                    sb    = $signed(v2);
                    r     = op[0] ? sa - sb : sa + sb;
                    m_res = r[DW-1:0];
                    m_ovf = (r > (2**(DW-1)) - 1) || (r < -(2**(DW-1)));
                    m_tag = id;
                    m_acc = ecnt;
                    m_inf = 1;
                end
            end else if (ecnt > m_acc + L && grant) begin
                m_bc = 1;
                m_bcasts++;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        check("busy", 32'(busy), 32'(m_inf));
        check("cdb_req", 32'(cdb_req), 32'(m_inf && !m_bc && (ecnt >= m_acc + L)));
        check("confirma", 32'(confirma), 32'(m_bc));
        check("cdb", 32'(cdb), m_bc ? 32'({m_tag, m_res}) : 32'd0);
        check("ovf", 32'(ovf), 32'(m_bc && m_ovf && OVF_ON));
        if (confirma) dut_bcasts++;
    end

    // Station: called at a negedge; holds the dispatch until confirma, then drops it.
    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] o,
                         input logic [TW-1:0] t, input bit rg,
                         output logic [TW+DW-1:0] got, output int n, output logic got_ovf);
        bit seen;
        despacho = 1; v1 = a; v2 = b; op = o; id = t;
        if (rg) grant = 1'($urandom_range(0, 1));
        n = 0; got = '0; got_ovf = 1'b0; seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (confirma) begin
                got = cdb; got_ovf = ovf; seen = 1;
                break;
            end
            if (rg) grant = 1'($urandom_range(0, 1));
        end
        despacho = 0;
        if (!seen) check("op_timeout", 32'd0, 32'd1);
    endtask

    logic [TW+DW-1:0] got;
    logic             gov;
    int               n;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cdb", 32'(cdb), 32'd0);
        clr = 0;
        @(negedge clk);

        // 1: basic add, latency and one-cycle confirma
        grant = 1;
        do_op(16'h0005, 16'h0003, 3'b000, 3'd3, 0, got, n, gov);
        check("t1_cdb", 32'(got), 32'h3_0008);
        check("t1_lat", 32'(n), 32'(L + 2));
        @(negedge clk);
        check("t1_conf_off", 32'(confirma), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);

        // 2: subtract wrap-around, OP[2:1] ignored
        do_op(16'h0000, 16'h0001, 3'b001, 3'd2, 0, got, n, gov);
        check("t2_cdb", 32'(got), 32'h2_FFFF);
        @(negedge clk);
        do_op(16'h0000, 16'h0001, 3'b101, 3'd2, 0, got, n, gov);
        check("t2_cdb_op101", 32'(got), 32'h2_FFFF);
        @(negedge clk);

        // 3: grant withheld, operands changed during the wait
        despacho = 1; v1 = 16'h1234; v2 = 16'h0034; op = 3'b001; id = 3'd4; grant = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t3_req", 32'(cdb_req), 32'd1);
            check("t3_cdb0", 32'(cdb), 32'd0);
            v1 = 16'($urandom); v2 = 16'($urandom);
            @(negedge clk);
        end
        grant = 1;
        @(negedge clk);
        check("t3_conf", 32'(confirma), 32'd1);
        check("t3_cdb", 32'(cdb), 32'h4_1200);
        despacho = 0;
        @(negedge clk);

        // 4: back-to-back, next station already waiting
        do_op(16'd10, 16'd20, 3'b000, 3'd3, 0, got, n, gov);
        check("t4_cdb3", 32'(got), 32'h3_001E);
        do_op(16'd100, 16'd1, 3'b001, 3'd5, 0, got, n, gov);
        check("t4_cdb5", 32'(got), 32'h5_0063);
        check("t4_lat5", 32'(n), 32'(L + 3));
        @(negedge clk);

        // 5: CLR during EXEC aborts; tag 0 never accepted
        despacho = 1; v1 = 16'h0101; v2 = 16'h0202; op = 3'b000; id = 3'd6;
        @(negedge clk);
        check("t5_busy_exec", 32'(busy), 32'd1);
        clr = 1; despacho = 0;
        #1;
        check("t5_busy_clr", 32'(busy), 32'd0);
        check("t5_req_clr", 32'(cdb_req), 32'd0);
        check("t5_conf_clr", 32'(confirma), 32'd0);
        check("t5_cdb_clr", 32'(cdb), 32'd0);
        @(negedge clk);
        clr = 0;
        repeat (6) begin
            @(negedge clk);
            check("t5_no_bcast", 32'(confirma), 32'd0);
        end
        despacho = 1; id = 3'd0;
        repeat (6) begin
            @(negedge clk);
            check("t5_id0_busy", 32'(busy), 32'd0);
        end
        despacho = 0;
        @(negedge clk);

        // 6: signed overflow
        do_op(16'h7FFF, 16'h0001, 3'b000, 3'd1, 0, got, n, gov);
        check("t6_cdb", 32'(got), 32'h1_8000);
        check("t6_ovf", 32'(gov), 32'(OVF_ON));
        @(negedge clk);

        // Random traffic with random grant, gaps and ignored tag-0 dispatches
        for (int k = 0; k < 150; k++) begin
            logic [TW-1:0] t;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            t = TW'($urandom_range(0, 7));
            if (t == 0) begin
                despacho = 1; id = '0; v1 = 16'($urandom); v2 = 16'($urandom);
                repeat (2) @(negedge clk);
                despacho = 0;
            end else begin
                do_op(16'($urandom), 16'($urandom), 3'($urandom), t, 1, got, n, gov);
            end
        end
        grant = 0;
        repeat (3) @(negedge clk);
        check("bcast_count", 32'(dut_bcasts), 32'(m_bcasts));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
